// File: rtl/hawk_axird_arb.sv
// Two-requester AXI read-channel arbiter (m0 = HAWK, m1 = CPU) with one outstanding
// transaction, HAWK priority with a starvation guard or plain round-robin.
//
// state | meaning
// IDLE  | arbitrate; winner's arready pulses and its AR payload is captured
// ADDR  | out_arvalid held with registered payload until out_arready
// DATA  | R beats routed to the owner until the out_rlast handshake
module hawk_axird_arb #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int ID_W       = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hawk_prio,

  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [7:0]        m0_arlen,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [ID_W-1:0]   m0_rid,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,

  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [7:0]        m1_arlen,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ID_W-1:0]   m1_rid,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,

  output logic              out_arvalid,
  input  logic              out_arready,
  output logic [ADDR_W-1:0] out_araddr,
  output logic [ID_W-1:0]   out_arid,
  output logic [7:0]        out_arlen,
  input  logic              out_rvalid,
  output logic              out_rready,
  input  logic [DATA_W-1:0] out_rdata,
  input  logic [ID_W-1:0]   out_rid,
  input  logic [1:0]        out_rresp,
  input  logic              out_rlast,

  output logic              busy,
  output logic              proto_err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e            state_q;
  logic              owner_q;      // 1 = m1 owns the outstanding read
  logic              last_gnt_q;   // 1 = m1 was granted most recently
  logic [SW-1:0]     starve_cnt_q;
  logic [7:0]        beat_cnt_q;
  logic              out_arvalid_q;
  logic              busy_q;
  logic              proto_err_q;
  logic [ADDR_W-1:0] out_araddr_q;
  logic [ID_W-1:0]   out_arid_q;
  logic [7:0]        out_arlen_q;

  logic starved;
  logic pick_m1;
  logic gnt;
  logic in_data;
  logic owner_rready;
  logic beat;

  always_comb begin
    starved = (starve_cnt_q == STARVE_LIM) && m1_arvalid;
    pick_m1 = m1_arvalid;
    if (m0_arvalid && m1_arvalid) begin
      pick_m1 = hawk_prio ? starved : !last_gnt_q;
    end
    // Gated by rst so no requester sees a handshake that reset will discard.
    gnt = !rst && (state_q == IDLE) && (m0_arvalid || m1_arvalid);
  end

  assign m0_arready = gnt && !pick_m1;
  assign m1_arready = gnt && pick_m1;

  assign in_data      = (state_q == DATA);
  assign owner_rready = owner_q ? m1_rready : m0_rready;
  assign out_rready   = in_data && owner_rready;
  assign m0_rvalid    = in_data && !owner_q && out_rvalid;
  assign m1_rvalid    = in_data && owner_q && out_rvalid;
  assign beat         = out_rvalid && out_rready;

  assign m0_rdata = out_rdata;
  assign m0_rid   = out_rid;
  assign m0_rresp = out_rresp;
  assign m0_rlast = out_rlast;
  assign m1_rdata = out_rdata;
  assign m1_rid   = out_rid;
  assign m1_rresp = out_rresp;
  assign m1_rlast = out_rlast;

  assign out_arvalid = out_arvalid_q;
  assign out_araddr  = out_araddr_q;
  assign out_arid    = out_arid_q;
  assign out_arlen   = out_arlen_q;
  assign busy        = busy_q;
  assign proto_err   = proto_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_gnt_q    <= 1'b1;
      starve_cnt_q  <= '0;
      beat_cnt_q    <= '0;
      out_arvalid_q <= 1'b0;
      busy_q        <= 1'b0;
      proto_err_q   <= 1'b0;
      out_araddr_q  <= '0;
      out_arid_q    <= '0;
      out_arlen_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt) begin
            state_q       <= ADDR;
            out_arvalid_q <= 1'b1;
            busy_q        <= 1'b1;
            owner_q       <= pick_m1;
            last_gnt_q    <= pick_m1;
            beat_cnt_q    <= '0;
            out_araddr_q  <= pick_m1 ? m1_araddr : m0_araddr;
            out_arid_q    <= pick_m1 ? m1_arid   : m0_arid;
            out_arlen_q   <= pick_m1 ? m1_arlen  : m0_arlen;
            if (pick_m1) begin
              starve_cnt_q <= '0;
            end else if (m1_arvalid && (starve_cnt_q != STARVE_LIM)) begin
              starve_cnt_q <= starve_cnt_q + 1'b1;
            end
          end
        end
        ADDR: begin
          if (out_arready) begin
            state_q       <= DATA;
            out_arvalid_q <= 1'b0;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            // rlast must coincide exactly with beat index == arlen.
            if (out_rlast != (beat_cnt_q == out_arlen_q)) begin
              proto_err_q <= 1'b1;
            end
            if (out_rlast) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          out_arvalid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
      if (!hawk_prio) begin
        starve_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hawk_axird_arb.sv
// Self-checking bench for hawk_axird_arb: arbitration table, randomized transactions
// against a grant-rule model, and hand-written error / reset sequences.
module tb_hawk_axird_arb;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 6;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst, hawk_prio;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [AW-1:0] m0_araddr;
  logic [IW-1:0] m0_arid, m0_rid;
  logic [7:0] m0_arlen;
  logic [DW-1:0] m0_rdata;
  logic [1:0] m0_rresp;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [AW-1:0] m1_araddr;
  logic [IW-1:0] m1_arid, m1_rid;
  logic [7:0] m1_arlen;
  logic [DW-1:0] m1_rdata;
  logic [1:0] m1_rresp;
  logic out_arvalid, out_arready, out_rvalid, out_rready, out_rlast;
  logic [AW-1:0] out_araddr;
  logic [IW-1:0] out_arid, out_rid;
  logic [7:0] out_arlen;
  logic [DW-1:0] out_rdata;
  logic [1:0] out_rresp;
  logic busy, proto_err;

  hawk_axird_arb #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .hawk_prio(hawk_prio),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_rdata(m0_rdata), .m0_rid(m0_rid), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_rdata(m1_rdata), .m1_rid(m1_rid), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr),
    .out_arid(out_arid), .out_arlen(out_arlen), .out_rvalid(out_rvalid),
    .out_rready(out_rready), .out_rdata(out_rdata), .out_rid(out_rid),
    .out_rresp(out_rresp), .out_rlast(out_rlast), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model state: who was granted last, consecutive m0 wins over a waiting m1,
  // and whether any malformed burst has been seen since reset.
  int   m_last;
  int   m_starve;
  logic m_perr;

  typedef struct {
    logic prio;
    logic v0;
    logic v1;
    int   exp_w;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_winner(input logic prio, input logic v0, input logic v1);
    if (!v0 && !v1) return -1;
    if (v0 != v1) return v1 ? 1 : 0;
    if (prio) return (m_starve >= SMAX) ? 1 : 0;
    return (m_last == 1) ? 0 : 1;
  endfunction

  task automatic clear_inputs();
    hawk_prio = 1'b0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_araddr = '0; m1_araddr = '0; m0_arid = '0; m1_arid = '0;
    m0_arlen = '0; m1_arlen = '0; m0_rready = 1'b0; m1_rready = 1'b0;
    out_arready = 1'b0; out_rvalid = 1'b0; out_rdata = '0; out_rid = '0;
    out_rresp = '0; out_rlast = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; out_rvalid = 1'b1; out_rlast = 1'b1;
    m0_rready = 1'b1; m1_rready = 1'b1; out_arready = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", out_arvalid, 0);
    chk("rst_arready", {m0_arready, m1_arready}, 0);
    chk("rst_rready", out_rready, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_araddr", out_araddr, 0);
    chk("rst_arlen", out_arlen, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    m_last = 1; m_starve = 0; m_perr = 1'b0;
  endtask

  // One complete read: arbitration cycle, ADDR with random out_arready delay,
  // DATA with random rvalid/rready until the beat carrying rlast (index rl_idx).
  task automatic run_txn(input logic prio, input logic v0, input logic v1, input int exp_w,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [7:0] len, input int rl_idx);
    logic [AW-1:0] wa;
    logic [IW-1:0] wid;
    logic orr, done, w1;
    int i, guard, waits;
    w1 = (exp_w == 1);
    hawk_prio = prio; m0_arvalid = v0; m1_arvalid = v1;
    m0_araddr = a0; m1_araddr = a1;
    m0_arid = IW'($urandom); m1_arid = IW'($urandom);
    m0_arlen = w1 ? (len ^ 8'h55) : len;
    m1_arlen = w1 ? len : (len ^ 8'h55);
    out_rvalid = 1'b1; out_rlast = 1'b1; out_arready = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("m0_arready", m0_arready, exp_w == 0);
    chk("m1_arready", m1_arready, exp_w == 1);
    chk("idle_out_rready", out_rready, 0);
    chk("idle_rvalid", {m0_rvalid, m1_rvalid}, 0);
    if (!prio) m_starve = 0;
    if (exp_w < 0) begin
      @(posedge clk); #1;
      m0_arvalid = 1'b0; m1_arvalid = 1'b0; out_rvalid = 1'b0; out_rlast = 1'b0;
      out_arready = 1'b0;
      chk("nogrant_busy", busy, 0);
      return;
    end
    m_last = exp_w;
    if (w1) m_starve = 0;
    else if (prio && v1 && m_starve < SMAX) m_starve++;
    wa = w1 ? a1 : a0;
    wid = w1 ? m1_arid : m0_arid;
    @(posedge clk); #1;
    if (w1) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    m0_araddr = ~a0; m1_araddr = ~a1;
    waits = $urandom_range(0, 2);
    for (int k = 0; k <= waits; k++) begin
      out_arready = (k == waits);
      @(negedge clk);
      chk("ar_valid", out_arvalid, 1);
      chk("ar_addr", out_araddr, wa);
      chk("ar_id", out_arid, wid);
      chk("ar_len", out_arlen, len);
      chk("addr_busy", busy, 1);
      chk("addr_out_rready", out_rready, 0);
      chk("addr_rvalid", {m0_rvalid, m1_rvalid}, 0);
      chk("addr_arready", {m0_arready, m1_arready}, 0);
      @(posedge clk); #1;
    end
    out_arready = 1'b0;
    i = 0; done = 1'b0; guard = 0;
    while (!done && guard < 200) begin
      out_rvalid = ($urandom_range(0, 3) != 0);
      orr = 1'($urandom_range(0, 1));
      if (w1) begin m1_rready = orr; m0_rready = 1'($urandom_range(0, 1)); end
      else begin m0_rready = orr; m1_rready = 1'($urandom_range(0, 1)); end
      out_rdata = {$urandom, $urandom};
      out_rid = IW'($urandom);
      out_rresp = 2'($urandom);
      out_rlast = (i == rl_idx);
      @(negedge clk);
      chk("own_rvalid", w1 ? m1_rvalid : m0_rvalid, out_rvalid);
      chk("oth_rvalid", w1 ? m0_rvalid : m1_rvalid, 0);
      chk("out_rready", out_rready, orr);
      chk("own_rdata", w1 ? m1_rdata : m0_rdata, out_rdata);
      chk("own_rid", w1 ? m1_rid : m0_rid, out_rid);
      chk("own_rresp", w1 ? m1_rresp : m0_rresp, out_rresp);
      chk("own_rlast", w1 ? m1_rlast : m0_rlast, out_rlast);
      chk("data_busy", busy, 1);
      if (out_rvalid && orr) begin
        if (out_rlast) done = 1'b1;
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    chk("data_done", done, 1);
    out_rvalid = 1'b0; out_rlast = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    if (rl_idx != int'(len)) m_perr = 1'b1;
    chk("end_busy", busy, 0);
    chk("proto_err", proto_err, m_perr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] len;
    logic p, v0, v1;
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Single read from m1, addr 0x1000, len 0.
    run_txn(1'b0, 1'b0, 1'b1, 1, 32'h0, 32'h1000, 8'd0, 0);

    // Round-robin, then HAWK priority with starvation after four m0 wins.
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, -1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 0};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 0};
    for (int j = 0; j < 19; j++) begin
      len = 8'($urandom_range(0, 3));
      run_txn(tbl[j].prio, tbl[j].v0, tbl[j].v1, tbl[j].exp_w,
              $urandom, $urandom, len, int'(len));
    end

    for (int j = 0; j < 40; j++) begin
      p = 1'($urandom_range(0, 1));
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      len = 8'($urandom_range(0, 3));
      run_txn(p, v0, v1, model_winner(p, v0, v1), $urandom, $urandom, len, int'(len));
    end

    // rlast missing on the beat where beat_cnt == arlen.
    run_txn(1'b1, 1'b1, 1'b0, 0, $urandom, $urandom, 8'd1, 2);
    do_reset();
    // rlast early on a len-3 burst; flag stays set across a clean read.
    run_txn(1'b1, 1'b1, 1'b0, 0, $urandom, $urandom, 8'd3, 2);
    run_txn(1'b1, 1'b0, 1'b1, 1, $urandom, $urandom, 8'd2, 2);

    // Reset after the first of four beats.
    hawk_prio = 1'b0; m1_arvalid = 1'b1; m1_araddr = 32'h2000; m1_arlen = 8'd3;
    @(posedge clk); #1;
    m1_arvalid = 1'b0; out_arready = 1'b1;
    @(posedge clk); #1;
    out_arready = 1'b0; out_rvalid = 1'b1; m1_rready = 1'b1; out_rlast = 1'b0;
    @(negedge clk);
    chk("r39_first_beat", m1_rvalid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("r39_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("r39_rready", out_rready, 0);
    chk("r39_arvalid", out_arvalid, 0);
    chk("r39_busy", busy, 0);
    chk("r39_proto_err", proto_err, 0);
    @(negedge clk);
    chk("r39_stray_rready", out_rready, 0);
    @(posedge clk); #1;
    clear_inputs();
    m_last = 1; m_starve = 0; m_perr = 1'b0;
    run_txn(1'b0, 1'b1, 1'b1, 0, $urandom, $urandom, 8'd1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
